// File: rtl/fb_pkg.sv
// Shared types, sizes and coordinate helpers for the framebuffer draw sequencer.
package fb_pkg;

   localparam int H_RES = 80;
   localparam int V_RES = 60;
   localparam int AW    = 13;
   localparam int CW    = 8;
   localparam int XW    = 7;
   localparam int YW    = 6;

   typedef enum logic [1:0] {OP_PLOT, OP_FILL, OP_CLEAR, OP_NOP} fb_op_e;

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FINISH} fsm_e;

   typedef struct packed {
      logic [XW-1:0] xs;
      logic [XW-1:0] xe;
      logic [YW-1:0] ys;
      logic [YW-1:0] ye;
   } fb_rect_t;

   function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] x);
      return (x > XW'(H_RES - 1)) ? XW'(H_RES - 1) : x;
   endfunction

   function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] y);
      return (y > YW'(V_RES - 1)) ? YW'(V_RES - 1) : y;
   endfunction

   // Clamp first, then order the corners so traversal always runs low to high.
   function automatic fb_rect_t make_rect(input fb_op_e op,
                                          input logic [XW-1:0] x0, input logic [YW-1:0] y0,
                                          input logic [XW-1:0] x1, input logic [YW-1:0] y1);
      fb_rect_t r;
      logic [XW-1:0] ax, bx;
      logic [YW-1:0] ay, by;
      ax = clamp_x(x0);
      bx = clamp_x(x1);
      ay = clamp_y(y0);
      by = clamp_y(y1);
      r.xs = ax;
      r.xe = ax;
      r.ys = ay;
      r.ye = ay;
      case (op)
         OP_FILL: begin
            r.xs = (ax < bx) ? ax : bx;
            r.xe = (ax < bx) ? bx : ax;
            r.ys = (ay < by) ? ay : by;
            r.ye = (ay < by) ? by : ay;
         end
         OP_CLEAR: begin
            r.xs = '0;
            r.xe = XW'(H_RES - 1);
            r.ys = '0;
            r.ye = YW'(V_RES - 1);
         end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational pixel address: y*H_RES + x, with y*80 built from two shifts.
module fb_addr_calc
   import fb_pkg::*;
(
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   output logic [AW-1:0] addr
);

   logic [AW-1:0] y_w;

   // y*80 = y*64 + y*16; the largest result (4799) fits in AW bits.
   always_comb begin
      y_w  = AW'(y);
      addr = (y_w << 6) + (y_w << 4) + AW'(x);
   end

endmodule

// File: rtl/fb_draw_sequencer.sv
// Expands PLOT / FILL_RECT / CLEAR / NOP commands into one-pixel-per-clock
// framebuffer writes. Every output is a register loaded from next-cycle values.
module fb_draw_sequencer
   import fb_pkg::*;
(
   input  logic          CLK_50MHz,
   input  logic          RESET,
   input  logic          CMD_VALID,
   output logic          CMD_READY,
   input  logic [1:0]    CMD_OP,
   input  logic [XW-1:0] X0,
   input  logic [YW-1:0] Y0,
   input  logic [XW-1:0] X1,
   input  logic [YW-1:0] Y1,
   input  logic [CW-1:0] COLOR,
   input  logic          ABORT,
   output logic          BUSY,
   output logic          DONE,
   output logic          FB_WE,
   output logic [AW-1:0] FB_WA,
   output logic [CW-1:0] FB_WD
);

   fsm_e          state, state_nxt;
   fb_rect_t      rect_in;
   logic [XW-1:0] xs_q, xe_q;
   logic [YW-1:0] ye_q;
   logic [CW-1:0] color_q;
   logic [XW-1:0] cur_x, x_nxt;
   logic [YW-1:0] cur_y, y_nxt;
   logic          accept, last_px;
   logic          ready_nxt, busy_nxt, done_nxt, we_nxt;
   logic [CW-1:0] wd_nxt;
   logic [AW-1:0] addr_nxt;

   assign rect_in = make_rect(fb_op_e'(CMD_OP), X0, Y0, X1, Y1);
   assign accept  = (state == S_IDLE) && CMD_VALID && CMD_READY;
   assign last_px = (cur_x == xe_q) && (cur_y == ye_q);

   // Address of the pixel written next cycle, so FB_WA leaves a register.
   fb_addr_calc u_addr_calc (
      .x    (x_nxt),
      .y    (y_nxt),
      .addr (addr_nxt)
   );

   // Next state, next pixel and next output values.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_nxt = state;
      x_nxt     = cur_x;
      y_nxt     = cur_y;
      ready_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      we_nxt    = 1'b0;
      wd_nxt    = '0;
      case (state)
         S_IDLE: begin
            ready_nxt = 1'b1;
            if (accept) begin
               ready_nxt = 1'b0;
               if (fb_op_e'(CMD_OP) == OP_NOP) begin
                  state_nxt = S_FINISH;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_DRAW;
                  x_nxt     = rect_in.xs;
                  y_nxt     = rect_in.ys;
                  busy_nxt  = 1'b1;
                  we_nxt    = 1'b1;
                  wd_nxt    = COLOR;
               end
            end
         end
         S_DRAW: begin
            if (ABORT) begin
               // Current write still completes; READY returns one cycle later.
               state_nxt = S_IDLE;
            end else if (last_px) begin
               state_nxt = S_FINISH;
               done_nxt  = 1'b1;
            end else begin
               busy_nxt = 1'b1;
               we_nxt   = 1'b1;
               wd_nxt   = color_q;
               if (cur_x == xe_q) begin
                  x_nxt = xs_q;
                  y_nxt = cur_y + YW'(1);
               end else begin
                  x_nxt = cur_x + XW'(1);
               end
            end
         end
         S_FINISH: begin
            state_nxt = S_IDLE;
            ready_nxt = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, pixel counters, latched command and registered outputs.
   always_ff @(posedge CLK_50MHz) begin
      // NOTE: there is no memory here, so every register takes the synchronous reset.
      if (RESET) begin
         state     <= S_IDLE;
         xs_q      <= '0;
         xe_q      <= '0;
         ye_q      <= '0;
         color_q   <= '0;
         cur_x     <= '0;
         cur_y     <= '0;
         CMD_READY <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         FB_WE     <= 1'b0;
         FB_WA     <= '0;
         FB_WD     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         state     <= state_nxt;
         cur_x     <= x_nxt;
         cur_y     <= y_nxt;
         CMD_READY <= ready_nxt;
         BUSY      <= busy_nxt;
         DONE      <= done_nxt;
         FB_WE     <= we_nxt;
         FB_WA     <= we_nxt ? addr_nxt : '0;
         FB_WD     <= wd_nxt;
         if (accept) begin
            xs_q    <= rect_in.xs;
            xe_q    <= rect_in.xe;
            ye_q    <= rect_in.ye;
            color_q <= COLOR;
         end
      end
   end

endmodule

// File: tb/tb_fb_draw_sequencer.sv
// Scoreboard bench for fb_draw_sequencer: expected writes are queued when a
// command is driven and popped by a monitor as FB_WE cycles appear.
module tb_fb_draw_sequencer;
   import fb_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [XW-1:0] x0, x1;
   logic [YW-1:0] y0, y1;
   logic [CW-1:0] color;
   logic          abort;
   logic          busy, done, fb_we;
   logic [AW-1:0] fb_wa;
   logic [CW-1:0] fb_wd;

   typedef struct {
      int wa;
      int wd;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_pass   = 0;
   int  n_total  = 0;
   int  done_cnt = 0;
   int  exp_done = 0;

   fb_draw_sequencer dut (
      .CLK_50MHz (clk),
      .RESET     (rst),
      .CMD_VALID (cmd_valid),
      .CMD_READY (cmd_ready),
      .CMD_OP    (cmd_op),
      .X0        (x0),
      .Y0        (y0),
      .X1        (x1),
      .Y1        (y1),
      .COLOR     (color),
      .ABORT     (abort),
      .BUSY      (busy),
      .DONE      (done),
      .FB_WE     (fb_we),
      .FB_WA     (fb_wa),
      .FB_WD     (fb_wd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Monitor: every write must match the head of the scoreboard, in order.
   always @(negedge clk) begin
      if (fb_we === 1'b1) begin
         check("write_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("fb_wa", int'(fb_wa), mon_e.wa);
            check("fb_wd", int'(fb_wd), mon_e.wd);
         end
      end
      if (done === 1'b1) done_cnt++;
   end

   // Waits for READY, queues the model's writes (first 'limit' only if limit>=0)
   // and drives the command for one accept cycle.
   task automatic issue(input logic [1:0] op, input int ax0, input int ay0,
                        input int ax1, input int ay1, input int c,
                        input int limit, output int n_full);
      int xa, xb, ya, yb, xs, xe, ys, ye, cnt;
      @(negedge clk);
      for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) @(negedge clk);
      check("ready_wait", int'(cmd_ready), 1);
      xa = (ax0 > 79) ? 79 : ax0;
      xb = (ax1 > 79) ? 79 : ax1;
      ya = (ay0 > 59) ? 59 : ay0;
      yb = (ay1 > 59) ? 59 : ay1;
      case (op)
         2'd0: begin xs = xa; xe = xa; ys = ya; ye = ya; end
         2'd1: begin
            xs = (xa < xb) ? xa : xb;  xe = (xa < xb) ? xb : xa;
            ys = (ya < yb) ? ya : yb;  ye = (ya < yb) ? yb : ya;
         end
         2'd2: begin xs = 0; xe = 79; ys = 0; ye = 59; end
         default: begin xs = 1; xe = 0; ys = 1; ye = 0; end
      endcase
      cnt = 0;
      for (int y = ys; y <= ye; y++)
         for (int x = xs; x <= xe; x++) begin
            if (limit < 0 || cnt < limit) exp_q.push_back('{wa: y * 80 + x, wd: c});
            cnt++;
         end
      n_full    = cnt;
      cmd_op    = op;
      x0        = XW'(ax0);
      y0        = YW'(ay0);
      x1        = XW'(ax1);
      y1        = YW'(ay1);
      color     = CW'(c);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      x0        = XW'($urandom);
      y0        = YW'($urandom);
      x1        = XW'($urandom);
      y1        = YW'($urandom);
      color     = CW'($urandom);
   endtask

   // Follows a command that must complete normally after n writes.
   task automatic finish_normal(input int n);
      int we_c = 0, busy_c = 0, rdy_c = 0, done_k = -1;
      for (int k = 1; k <= n + 5 && done_k < 0; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_k = k;
            check("we_at_done", int'(fb_we), 0);
            check("busy_at_done", int'(busy), 0);
         end else begin
            we_c   += int'(fb_we);
            busy_c += int'(busy);
         end
         rdy_c += int'(cmd_ready);
      end
      check("done_latency", done_k, n + 1);
      check("we_cycles", we_c, n);
      check("busy_cycles", busy_c, n);
      check("ready_while_busy", rdy_c, 0);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("ready_after_done", int'(cmd_ready), 1);
      check("scoreboard_empty", exp_q.size(), 0);
   endtask

   task automatic run(input logic [1:0] op, input int ax0, input int ay0,
                      input int ax1, input int ay1, input int c);
      int n;
      issue(op, ax0, ay0, ax1, ay1, c, -1, n);
      exp_done++;
      finish_normal(n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; abort = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", int'(cmd_ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_we", int'(fb_we), 0);
      check("rst_wa", int'(fb_wa), 0);
      check("rst_wd", int'(fb_wd), 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", int'(cmd_ready), 1);

      run(OP_PLOT, 5, 2, 0, 0, 8'hE5);
      run(OP_FILL, 3, 1, 1, 2, 8'hFF);
      run(OP_CLEAR, 17, 33, 4, 9, 8'h00);
      run(OP_PLOT, 100, 63, 0, 0, 8'h3C);
      run(OP_PLOT, 127, 63, 0, 0, 8'h11);
      run(OP_FILL, 120, 50, 75, 62, 8'hA5);
      run(OP_FILL, 79, 59, 79, 59, 8'h5A);
      for (int i = 0; i < 4; i++)
         run(OP_FILL, $urandom_range(127), $urandom_range(63),
             $urandom_range(127), $urandom_range(63), $urandom_range(255));

      // CLEAR aborted during its 10th write.
      issue(OP_CLEAR, 0, 0, 0, 0, 8'h77, 10, n);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 10) begin
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
         end
      end
      @(negedge clk);
      check("abort_we_off", int'(fb_we), 0);
      check("abort_no_done", int'(done), 0);
      check("abort_busy_off", int'(busy), 0);
      check("abort_ready_low", int'(cmd_ready), 0);
      @(negedge clk);
      check("abort_ready_high", int'(cmd_ready), 1);
      check("abort_writes", exp_q.size(), 0);
      run(OP_PLOT, 0, 0, 0, 0, 8'h42);

      // Reset in the middle of a FILL_RECT, after its 5th write.
      issue(OP_FILL, 10, 10, 30, 20, 8'hC3, 5, n);
      for (int k = 1; k <= 5; k++) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_we", int'(fb_we), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_ready", int'(cmd_ready), 0);
      check("midrst_wa", int'(fb_wa), 0);
      check("midrst_wd", int'(fb_wd), 0);
      check("midrst_writes", exp_q.size(), 0);
      run(OP_NOP, 3, 3, 3, 3, 8'h99);

      repeat (3) @(negedge clk);
      check("done_pulses", done_cnt, exp_done);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fb_draw_sequencer.md
Name: fb_draw_sequencer

Overview:
Command-driven write sequencer for the 80x60 8-bit SPI framebuffer driver.
- Accepts PLOT, FILL_RECT, CLEAR and NOP commands over a valid/ready handshake.
- Expands each command into a stream of one-pixel-per-clock writes on the driver's WE/WA/WD port.
- Sits between the UART command decoder (or other host logic) and spi_fb_driver_80x60, and is the only writer of the framebuffer.

Parameters:
H_RES, 80, pixels per row
V_RES, 60, rows
AW, 13, framebuffer address width (ceil(log2(H_RES*V_RES)))
CW, 8, pixel colour width

Ports:
CLK_50MHz  in  1  system clock
RESET  in  1  synchronous active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  sequencer can accept a command
CMD_OP  in  2  0=PLOT, 1=FILL_RECT, 2=CLEAR, 3=NOP
X0  in  7  start column
Y0  in  6  start row
X1  in  7  end column (FILL_RECT only)
Y1  in  6  end row (FILL_RECT only)
COLOR  in  CW  fill colour
ABORT  in  1  cancel the command in progress
BUSY  out  1  command in progress
DONE  out  1  one-cycle pulse when a command completes normally
FB_WE  out  1  framebuffer write enable
FB_WA  out  AW  framebuffer address = y*H_RES + x
FB_WD  out  CW  framebuffer write data

Behaviour:
Clock and reset:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: CMD_READY=0 during the reset cycle, then 1. BUSY=0, DONE=0, FB_WE=0, FB_WA=0, FB_WD=0.
- FSM resets to IDLE.
- RESET mid-command: stops writes the next cycle; no DONE.

States:
- IDLE: CMD_READY=1. On CMD_VALID&CMD_READY, latch op, coordinates and COLOR.
  - NOP goes to FINISH.
  - All other ops go to DRAW.
- DRAW: CMD_READY=0, BUSY=1, FB_WE=1 every cycle, FB_WD=latched COLOR, FB_WA=cur_y*H_RES+cur_x.
  - Traversal is row-major.
  - At end of row (cur_x==xe): cur_x<=xs, cur_y<=cur_y+1.
  - On the last pixel (cur_x==xe && cur_y==ye): go to FINISH.
- FINISH: DONE=1 for exactly one cycle, BUSY=0, FB_WE=0. Return to IDLE; CMD_READY=1 the following cycle.

Timing:
- First FB_WE is the cycle after acceptance.
- A rect of W x H pixels produces exactly W*H consecutive FB_WE cycles.
- DONE occurs the cycle after the last write.
- Next command acceptance is 2 cycles after the last write at the earliest.

Coordinate rules, applied at acceptance:
- PLOT: xs=xe=X0, ys=ye=Y0.
- CLEAR: xs=0, ys=0, xe=H_RES-1, ye=V_RES-1; X/Y inputs ignored.
- FILL_RECT: xs=min(X0,X1), xe=max(X0,X1), and likewise for y (swapped corners are legal).
- Clamping: any x>H_RES-1 clamps to H_RES-1; any y>V_RES-1 clamps to V_RES-1. Clamping applies before the swap. Example: PLOT at (127,63) writes address 4799.

Address arithmetic:
- y*80 = (y<<6)+(y<<4), computed in AW bits.
- The maximum address is 4799, so there is no wrap-around.
- The address is registered together with FB_WE, so there is no combinational path from the counters to FB_WA.

ABORT:
- Sampled in DRAW only; ignored in IDLE and FINISH.
- ABORT=1 in DRAW: the write in that cycle is still issued, FB_WE=0 from the next cycle, and the FSM returns to IDLE with no DONE pulse.

CMD_VALID while busy: held off by CMD_READY=0. Command inputs are not sampled outside the accept cycle.

Decomposition:
Package fb_pkg:
- H_RES, V_RES, AW, CW.
- typedef enum logic [1:0] fb_op_e {OP_PLOT, OP_FILL, OP_CLEAR, OP_NOP}.
- typedef enum fsm_e {S_IDLE, S_DRAW, S_FINISH}.
- typedef struct fb_rect_t {xs, xe, ys, ye}.

Sub-module fb_addr_calc: combinational (x,y) -> AW-bit address using shift-add. It is reused by future read-path logic.

Test Plan:
1. PLOT op=0, X0=5, Y0=2, COLOR=8'hE5 -> one FB_WE cycle with WA=165, WD=E5, then DONE next cycle; BUSY high exactly 1 cycle.
2. FILL_RECT X0=3, Y0=1, X1=1, Y1=2, COLOR=8'hFF (swapped x) -> 6 writes at WA 81, 82, 83, 161, 162, 163 in order, then DONE.
3. CLEAR COLOR=8'h00 -> 4800 consecutive FB_WE cycles, WA 0..4799 incrementing by 1, then one DONE pulse; CMD_READY=0 throughout.
4. PLOT X0=100, Y0=63 -> clamped, single write at WA=4799.
5. CLEAR, ABORT pulsed on the 10th write cycle -> exactly 10 writes (WA 0..9), no DONE, CMD_READY=1 two cycles after the abort; a following PLOT at (0,0) is accepted and completes normally.
6. RESET asserted mid-FILL_RECT -> FB_WE=0 the next cycle, all outputs at reset values; NOP afterwards -> DONE one cycle after acceptance with no FB_WE.
